// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: register map, bit positions,
// FSM state encoding and note-entry layout.
package melody_sequencer_pkg;

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_GAPT = 3'd1;
    localparam logic [2:0] REG_PUSH = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_IRQEN = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_DONE  = 4;

    localparam logic [3:0] NOTE_SILENCE = 4'd0;
    localparam logic [3:0] NOTE_MAX     = 4'd14;

    localparam int ENTRY_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_NOTE = 3'd2,
        ST_GAP  = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0]  note;
        logic [15:0] dur;
    } entry_t;

endpackage

// File: rtl/melody_note_ram.sv
// Note-list storage: DEPTH x 20-bit entries {note, dur}, synchronous write,
// registered read with one cycle of latency.
module melody_note_ram
    import melody_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Write port; the array is left unreset so it can map onto memory.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Bus-mapped note sequencer feeding the buzzer tone stage.
// Optional done interrupt enabled by defining MELODY_DONE_IRQ_EN.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int MS_DIV = 50000
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  addrIn,
    input  logic [7:0]  addrOut,
    input  logic [3:0]  sizeDecode,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [3:0]  noteCode,
    output logic        noteValid,
    output logic        busy,
    output logic        irq
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);

    state_t        state_r, state_nx_s;
    entry_t        rd_entry_s;
    logic [CW-1:0] count_r;
    logic [IW-1:0] idx_r, idx_nx_s, wr_ptr_r;
    logic [PW-1:0] pre_r;
    logic [15:0]   ms_left_r, gapt_r;
    logic          loop_r, irqen_r, irqen_nx_s, overflow_r, done_r, done_nx_s, irq_nx_s;
    logic          wr_en_s, wr_ctrl_s, wr_gapt_s, wr_push_s, wr_stat_s;
    logic          start_s, clear_s, full_s, empty_s, push_ok_s, push_drop_s;
    logic          more_s, tick_end_s, finish_s;
    logic          note_valid_s, busy_s;
    logic [3:0]    note_code_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign wr_en_s     = |sizeDecode;
    assign wr_ctrl_s   = wr_en_s && (addrIn[2:0] == REG_CTRL);
    assign wr_gapt_s   = wr_en_s && (addrIn[2:0] == REG_GAPT);
    assign wr_push_s   = wr_en_s && (addrIn[2:0] == REG_PUSH);
    assign wr_stat_s   = wr_en_s && (addrIn[2:0] == REG_STAT);
    assign start_s     = wr_ctrl_s && dataIn[CTRL_START];
    assign clear_s     = wr_ctrl_s && dataIn[CTRL_CLEAR];
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_ok_s   = wr_push_s && !clear_s && !full_s;
    assign push_drop_s = wr_push_s && !clear_s && full_s;
    assign more_s      = (({1'b0, idx_r}) + CW'(1)) < count_r;
    // The last prescaler cycle of the last millisecond ends a NOTE or GAP.
    assign tick_end_s  = (pre_r == PRE_LAST) && (ms_left_r == 16'd1);
    assign finish_s    = (state_r == ST_NEXT) && (state_nx_s == ST_IDLE) && !clear_s;
    assign unused_s    = ^{addrIn, addrOut, dataIn};

`ifdef MELODY_DONE_IRQ_EN
    assign irqen_nx_s = wr_ctrl_s ? dataIn[CTRL_IRQEN] : irqen_r;
    assign irq_nx_s   = done_nx_s && irqen_nx_s;
`else
    assign irqen_nx_s = 1'b0;
    assign irq_nx_s   = 1'b0;
`endif

    melody_note_ram #(.DEPTH(DEPTH), .AW(IW)) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (push_ok_s),
        .waddr (wr_ptr_r),
        .wdata (dataIn[ENTRY_W-1:0]),
        .raddr (idx_nx_s),
        .rdata (rd_entry_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; CLEAR overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (clear_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = (start_s && !empty_s) ? ST_LOAD : ST_IDLE;
                ST_LOAD: state_nx_s = (rd_entry_s.dur != 16'd0) ? ST_NOTE : ST_NEXT;
                ST_NOTE: begin
                    if (tick_end_s) begin
                        state_nx_s = (gapt_r != 16'd0) ? ST_GAP : ST_NEXT;
                    end else begin
                        state_nx_s = ST_NOTE;
                    end
                end
                ST_GAP:  state_nx_s = tick_end_s ? ST_NEXT : ST_GAP;
                ST_NEXT: state_nx_s = (more_s || loop_r) ? ST_LOAD : ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Next entry index; also drives the RAM read address so LOAD sees the entry.
    always_comb begin
        idx_nx_s = idx_r;
        if (clear_s) begin
            idx_nx_s = {IW{1'b0}};
        end else if ((state_r == ST_IDLE) && (state_nx_s == ST_LOAD)) begin
            idx_nx_s = {IW{1'b0}};
        end else if (state_r == ST_NEXT) begin
            if (more_s) begin
                idx_nx_s = idx_r + IW'(1);
            end else if (loop_r) begin
                idx_nx_s = {IW{1'b0}};
            end else begin
                idx_nx_s = idx_r;
            end
        end else begin
            idx_nx_s = idx_r;
        end
    end

    // Done flag: set on natural end of playback, cleared by any STAT write.
    always_comb begin
        if (finish_s) begin
            done_nx_s = 1'b1;
        end else if (wr_stat_s) begin
            done_nx_s = 1'b0;
        end else begin
            done_nx_s = done_r;
        end
    end

    // Millisecond prescaler and duration counter, restarted on each NOTE/GAP entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_r     <= '0;
            ms_left_r <= 16'd0;
        end else if ((state_nx_s == ST_NOTE) && (state_r != ST_NOTE)) begin
            pre_r     <= '0;
            ms_left_r <= rd_entry_s.dur;
        end else if ((state_nx_s == ST_GAP) && (state_r != ST_GAP)) begin
            pre_r     <= '0;
            ms_left_r <= gapt_r;
        end else if ((state_r == ST_NOTE) || (state_r == ST_GAP)) begin
            if (pre_r == PRE_LAST) begin
                pre_r     <= '0;
                ms_left_r <= ms_left_r - 16'd1;
            end else begin
                pre_r     <= pre_r + PW'(1);
            end
        end else begin
            pre_r     <= '0;
        end
    end

    // Software-visible registers, list bookkeeping and playback index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loop_r     <= 1'b0;
            irqen_r    <= 1'b0;
            gapt_r     <= 16'd0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            idx_r      <= '0;
        end else begin
            if (wr_ctrl_s) begin
                loop_r <= dataIn[CTRL_LOOP];
            end
            if (wr_gapt_s) begin
                gapt_r <= dataIn[15:0];
            end
            if (wr_stat_s) begin
                overflow_r <= 1'b0;
            end else if (push_drop_s) begin
                overflow_r <= 1'b1;
            end
            if (clear_s) begin
                count_r  <= '0;
                wr_ptr_r <= '0;
            end else if (push_ok_s) begin
                count_r  <= count_r + CW'(1);
                wr_ptr_r <= wr_ptr_r + IW'(1);
            end
            irqen_r <= irqen_nx_s;
            done_r  <= done_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Output decode from the upcoming state so outputs track the state register.
    always_comb begin
        note_valid_s = 1'b0;
        note_code_s  = NOTE_SILENCE;
        busy_s       = 1'b1;
        case (state_nx_s)
            ST_IDLE: busy_s = 1'b0;
            ST_NOTE: begin
                note_valid_s = 1'b1;
                note_code_s  = rd_entry_s.note;
            end
            ST_LOAD, ST_GAP, ST_NEXT: busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Registered tone-stage outputs and interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            noteCode  <= NOTE_SILENCE;
            noteValid <= 1'b0;
            busy      <= 1'b0;
            irq       <= 1'b0;
        end else begin
            noteCode  <= note_code_s;
            noteValid <= note_valid_s;
            busy      <= busy_s;
            irq       <= irq_nx_s;
        end
    end

    // Read-data mux.
    always_comb begin
        rdata_s = 32'd0;
        case (addrOut[2:0])
            REG_CTRL: begin
                rdata_s[CTRL_LOOP]  = loop_r;
                rdata_s[CTRL_IRQEN] = irqen_r;
            end
            REG_GAPT: rdata_s[15:0] = gapt_r;
            REG_PUSH: rdata_s = 32'd0;
            REG_STAT: begin
                rdata_s[STAT_BUSY]  = busy;
                rdata_s[STAT_FULL]  = full_s;
                rdata_s[STAT_EMPTY] = empty_s;
                rdata_s[STAT_OVF]   = overflow_r;
                rdata_s[STAT_DONE]  = done_r;
                rdata_s[15:8]       = 8'(count_r);
                rdata_s[23:16]      = 8'(idx_r);
            end
            default: rdata_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle behind addrOut.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dataOut <= 32'd0;
        end else begin
            dataOut <= rdata_s;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: randomized note lists checked
// against a timeline model of playback (LOAD, note, gap, NEXT per entry).
`timescale 1ns/1ps
module tb_melody_sequencer;

    localparam int DEPTH = 8;
    localparam int MS    = 10;
    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_GAPT = 3'd1;
    localparam logic [2:0] A_PUSH = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  addrIn = 8'd0;
    logic [7:0]  addrOut = 8'd0;
    logic [3:0]  sizeDecode = 4'd0;
    logic [31:0] dataIn = 32'd0;
    logic [31:0] dataOut;
    logic [3:0]  noteCode;
    logic        noteValid;
    logic        busy;
    logic        irq;

    int n_checks = 0;
    int n_pass = 0;
    int ent_note[$];
    int ent_dur[$];
    logic [5:0] exp_q[$];
    int pass_len = 0;

    melody_sequencer #(.DEPTH(DEPTH), .MS_DIV(MS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .addrIn     (addrIn),
        .addrOut    (addrOut),
        .sizeDecode (sizeDecode),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .noteCode   (noteCode),
        .noteValid  (noteValid),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addrIn     = {5'($urandom_range(0, 31)), a};
        dataIn     = d;
        sizeDecode = 4'($urandom_range(1, 15));
        @(negedge clk);
        sizeDecode = 4'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addrOut = {5'd0, a};
        @(negedge clk);
        d = dataOut;
    endtask

    task automatic push(input int note, input int dur);
        bus_write(A_PUSH, {12'd0, 4'(note), 16'(dur)});
        if (ent_note.size() < DEPTH) begin
            ent_note.push_back(note);
            ent_dur.push_back(dur);
        end
    endtask

    task automatic clear_all();
        bus_write(A_CTRL, 32'h4);
        bus_write(A_STAT, 32'h0);
        ent_note.delete();
        ent_dur.delete();
    endtask

    // Expected {busy, noteValid, noteCode} for every cycle after START.
    task automatic build_trace(input int passes, input int gap, input int tail);
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < ent_note.size(); i++) begin
                exp_q.push_back(6'b100000);
                for (int c = 0; c < ent_dur[i] * MS; c++) exp_q.push_back({2'b11, 4'(ent_note[i])});
                if (ent_dur[i] != 0)
                    for (int c = 0; c < gap * MS; c++) exp_q.push_back(6'b100000);
                exp_q.push_back(6'b100000);
            end
            if (p == 0) pass_len = exp_q.size();
        end
        for (int t = 0; t < tail; t++) exp_q.push_back(6'b000000);
    endtask

    task automatic run_trace(input string name, input int mid_at, input logic [2:0] mid_a,
                             input logic [31:0] mid_d);
        int bad;
        int first;
        logic [5:0] act, a_first, e_first;
        bad = 0; first = -1; a_first = 6'd0; e_first = 6'd0;
        for (int k = 0; k < exp_q.size(); k++) begin
            act = {busy, noteValid, noteCode};
            if (act !== exp_q[k]) begin
                if (bad == 0) begin
                    first = k; a_first = act; e_first = exp_q[k];
                end
                bad++;
            end
            if (k == mid_at) begin
                addrIn = {5'd0, mid_a}; dataIn = mid_d; sizeDecode = 4'hF;
            end else begin
                sizeDecode = 4'h0;
            end
            @(negedge clk);
        end
        sizeDecode = 4'h0;
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL trace_%s: %0d bad cycles, first at %0d: got busy/valid/code=%b/%b/%0d want %b/%b/%0d",
                      name, bad, first, a_first[5], a_first[4], a_first[3:0],
                      e_first[5], e_first[4], e_first[3:0]);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dataOut, noteCode, noteValid, busy, irq} !== 39'd0)
            $display("FAIL reset_outputs: got %h want 0", {dataOut, noteCode, noteValid, busy, irq});
        else n_pass++;
        rstn = 1'b1;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 32'h4) $display("FAIL reset_stat: got %h want %h", d, 32'h4); else n_pass++;
        bus_read(A_GAPT, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_gapt: got %h want 0", d); else n_pass++;
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL start_empty: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd1);
        push(5, 3);
        push(8, 2);
        build_trace(1, 1, 3);
        bus_write(A_CTRL, 32'h1);
        run_trace("basic", 5, A_CTRL, 32'h1);
        bus_read(A_STAT, d);
        n_checks++;
        if ((d & 32'hFFFF) !== 32'h0210) $display("FAIL basic_stat: got %h want %h", d & 32'hFFFF, 32'h0210);
        else n_pass++;
    endtask

    task automatic test_loop();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd0);
        push(1, 1);
        push(2, 1);
        build_trace(3, 0, 3);
        bus_write(A_CTRL, 32'h3);
        run_trace("loop", 2 * pass_len + 2, A_CTRL, 32'h0);
        bus_read(A_STAT, d);
        n_checks++;
        if ((d & 32'h1F) !== 32'h10) $display("FAIL loop_done: got %h want %h", d & 32'h1F, 32'h10);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) push(i + 1, 1);
        bus_read(A_STAT, d);
        n_checks++;
        if ((d & 32'hFFFF) !== 32'h080A) $display("FAIL ovf_stat: got %h want %h", d & 32'hFFFF, 32'h080A);
        else n_pass++;
        bus_write(A_STAT, 32'h0);
        bus_read(A_STAT, d);
        n_checks++;
        if ((d & 32'hFFFF) !== 32'h0802) $display("FAIL ovf_sticky_clr: got %h want %h", d & 32'hFFFF, 32'h0802);
        else n_pass++;
        build_trace(1, 0, 3);
        bus_write(A_CTRL, 32'h1);
        run_trace("overflow", -1, A_CTRL, 32'h0);
    endtask

    task automatic test_clear_mid();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd0);
        push(6, 5);
        bus_write(A_CTRL, 32'h1);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({noteValid, noteCode} !== 5'b10110) $display("FAIL clear_pre: got %b want %b", {noteValid, noteCode}, 5'b10110);
        else n_pass++;
        bus_write(A_CTRL, 32'h4);
        n_checks++;
        if ({busy, noteValid} !== 2'b00) $display("FAIL clear_outputs: got %b want 00", {busy, noteValid});
        else n_pass++;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 32'h4) $display("FAIL clear_stat: got %h want %h", d, 32'h4); else n_pass++;
    endtask

    task automatic test_dur_zero();
        clear_all();
        bus_write(A_GAPT, 32'd0);
        push(3, 2);
        push(7, 0);
        push(4, 2);
        build_trace(1, 0, 3);
        bus_write(A_CTRL, 32'h1);
        run_trace("dur_zero", -1, A_CTRL, 32'h0);
    endtask

    task automatic test_random();
        int n, gap, lp;
        for (int it = 0; it < 4; it++) begin
            clear_all();
            n   = $urandom_range(1, 5);
            gap = $urandom_range(0, 2);
            lp  = $urandom_range(0, 1);
            bus_write(A_GAPT, 32'(gap));
            for (int i = 0; i < n; i++) push($urandom_range(0, 14), $urandom_range(0, 3));
            build_trace((lp != 0) ? 2 : 1, gap, 3);
            bus_write(A_CTRL, (lp != 0) ? 32'h3 : 32'h1);
            run_trace($sformatf("random%0d", it), (lp != 0) ? pass_len : -1, A_CTRL, 32'h0);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd0);
        push(9, 1);
        build_trace(1, 0, 2);
        bus_write(A_CTRL, 32'h9);
        run_trace("irq", -1, A_CTRL, 32'h0);
`ifdef MELODY_DONE_IRQ_EN
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq); else n_pass++;
        bus_read(A_CTRL, d);
        n_checks++;
        if ((d & 32'hF) !== 32'h8) $display("FAIL irq_ctrl: got %h want 8", d & 32'hF); else n_pass++;
        bus_write(A_STAT, 32'h0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else n_pass++;
`else
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_tied: got %b want 0", irq); else n_pass++;
        bus_read(A_CTRL, d);
        n_checks++;
        if ((d & 32'hF) !== 32'h0) $display("FAIL irqen_reads0: got %h want 0", d & 32'hF); else n_pass++;
        bus_read(A_STAT, d);
        n_checks++;
        if ((d & 32'h10) !== 32'h10) $display("FAIL done_noirq: got %h want 10", d & 32'h10); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        clear_all();
        bus_write(A_GAPT, 32'd0);
        push(11, 4);
        bus_write(A_CTRL, 32'h1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (noteValid !== 1'b1) $display("FAIL arst_pre: got valid=%b want 1", noteValid); else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, noteValid, noteCode} !== 6'd0)
            $display("FAIL arst_silence: got %b want 000000", {busy, noteValid, noteCode});
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 32'h4) $display("FAIL arst_stat: got %h want %h", d, 32'h4); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_overflow();
        test_clear_mid();
        test_dur_zero();
        test_random();
        test_irq();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
